ap_txn_profiler: RTL

- Synthesizable per-transaction profiler for one ap_ctrl_hs/ap_ctrl_chain HLS block, such as the decision_function core. It taps the block-level handshake.
- For each transaction it produces one timestamped record: id, latency, initiation interval and continue-stall. Records leave on a valid/ready stream.
- Sits directly upstream of the module-status sampling/dump stage. It gives on-chip runs the same status data that cosim dumps to CSV.

---
 rtl/ap_txn_profiler.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ap_txn_profiler.sv
// ap_txn_profiler: per-transaction profiler for an ap_ctrl_hs/ap_ctrl_chain block.
// Watches the block-level handshake and, for every completed transaction,
// emits {id, latency, interval, stall} on a valid/ready record stream.
module ap_txn_profiler #(
    parameter int CNT_W = 32,
    parameter int ID_W  = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       ap_start,
    input  logic                       ap_ready,
    input  logic                       ap_done,
    input  logic                       ap_continue,
    input  logic                       finish,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [ID_W-1:0]            rec_id,
    output logic [CNT_W-1:0]           rec_latency,
    output logic [CNT_W-1:0]           rec_interval,
    output logic [CNT_W-1:0]           rec_stall,
    output logic [$clog2(DEPTH):0]     in_flight,
    output logic [15:0]                drop_cnt,
    output logic                       orphan_err,
    output logic                       finished
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_DRAIN    = 2'd2;
    localparam logic [1:0] ST_FINISHED = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] last_start_ts;
    logic             have_start;
    logic [CNT_W-1:0] stall_acc;
    logic [ID_W-1:0]  next_id;
    logic [15:0]      drops;
    logic             orphan;

    // In-flight start timestamps and the interval measured at each start
    logic [CNT_W-1:0] ts_mem [DEPTH];
    logic [CNT_W-1:0] iv_mem [DEPTH];
    logic [AW-1:0]    ts_wr;
    logic [AW-1:0]    ts_rd;
    logic [AW:0]      ts_cnt;

    // Completed records waiting for the consumer
    logic [ID_W-1:0]  rid_mem  [DEPTH];
    logic [CNT_W-1:0] rlat_mem [DEPTH];
    logic [CNT_W-1:0] riv_mem  [DEPTH];
    logic [CNT_W-1:0] rst_mem  [DEPTH];
    logic [AW-1:0]    rec_wr;
    logic [AW-1:0]    rec_rd;
    logic [AW:0]      rec_cnt;

    logic             start_en;
    logic             done_en;
    logic             ts_empty;
    logic             ts_full;
    logic             ts_pop;
    logic             ts_push;
    logic             bypass;
    logic             orphan_hit;
    logic             start_drop;
    logic             start_taken;
    logic [CNT_W-1:0] new_interval;
    logic             rec_make;
    logic             rec_pop;
    logic             rec_push;
    logic             rec_drop;
    logic [CNT_W-1:0] rec_lat_new;
    logic [CNT_W-1:0] rec_iv_new;

    // Event decode: pop is resolved before push, so a full FIFO still takes a start alongside a done
    always_comb begin
        start_en     = ap_start && ap_ready && ((state == ST_IDLE) || (state == ST_RUN));
        done_en      = ap_done && ap_continue && (state != ST_FINISHED);
        ts_empty     = (ts_cnt == '0);
        ts_full      = (ts_cnt == FULL_CNT);
        ts_pop       = done_en && !ts_empty;
        bypass       = done_en && ts_empty && start_en;
        orphan_hit   = done_en && ts_empty && !start_en;
        ts_push      = start_en && !bypass && (!ts_full || ts_pop);
        start_drop   = start_en && !bypass && ts_full && !ts_pop;
        start_taken  = ts_push || bypass;
        new_interval = have_start ? (cyc - last_start_ts) : '0;
        rec_make     = ts_pop || bypass;
        rec_pop      = (rec_cnt != '0) && rec_ready;
        rec_push     = rec_make && ((rec_cnt != FULL_CNT) || rec_pop);
        rec_drop     = rec_make && !rec_push;
        rec_lat_new  = bypass ? '0 : (cyc - ts_mem[ts_rd]);
        rec_iv_new   = bypass ? new_interval : iv_mem[ts_rd];
    end

    // Free-running saturating cycle counter plus start bookkeeping
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc           <= '0;
            last_start_ts <= '0;
            have_start    <= 1'b0;
        end else begin
            if (cyc != '1) begin
                cyc <= cyc + 1'b1;
            end
            if (start_taken) begin
                last_start_ts <= cyc;
                have_start    <= 1'b1;
            end
        end
    end

    // Continue-stall accumulator, handed to the record on the done event
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_acc <= '0;
        end else if (done_en) begin
            stall_acc <= '0;
        end else if (ap_done && !ap_continue && (stall_acc != '1)) begin
            stall_acc <= stall_acc + 1'b1;
        end
    end

    // Timestamp FIFO holding one entry per started transaction
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ts_wr  <= '0;
            ts_rd  <= '0;
            ts_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ts_mem[i] <= '0;
                iv_mem[i] <= '0;
            end
        end else begin
            if (ts_push) begin
                ts_mem[ts_wr] <= cyc;
                iv_mem[ts_wr] <= new_interval;
                ts_wr         <= ts_wr + 1'b1;
            end
            if (ts_pop) begin
                ts_rd <= ts_rd + 1'b1;
            end
            case ({ts_push, ts_pop})
                2'b10:   ts_cnt <= ts_cnt + 1'b1;
                2'b01:   ts_cnt <= ts_cnt - 1'b1;
                default: ts_cnt <= ts_cnt;
            endcase
        end
    end

    // Record FIFO, read first-word-fall-through from the head entry
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rec_wr  <= '0;
            rec_rd  <= '0;
            rec_cnt <= '0;
            next_id <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rid_mem[i]  <= '0;
                rlat_mem[i] <= '0;
                riv_mem[i]  <= '0;
                rst_mem[i]  <= '0;
            end
        end else begin
            if (rec_make) begin
                next_id <= next_id + 1'b1;
            end
            if (rec_push) begin
                rid_mem[rec_wr]  <= next_id;
                rlat_mem[rec_wr] <= rec_lat_new;
                riv_mem[rec_wr]  <= rec_iv_new;
                rst_mem[rec_wr]  <= stall_acc;
                rec_wr           <= rec_wr + 1'b1;
            end
            if (rec_pop) begin
                rec_rd <= rec_rd + 1'b1;
            end
            case ({rec_push, rec_pop})
                2'b10:   rec_cnt <= rec_cnt + 1'b1;
                2'b01:   rec_cnt <= rec_cnt - 1'b1;
                default: rec_cnt <= rec_cnt;
            endcase
        end
    end

    // Saturating drop counter and sticky orphan-done flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drops  <= '0;
            orphan <= 1'b0;
        end else begin
            if ((start_drop || rec_drop) && (drops != 16'hFFFF)) begin
                drops <= drops + 1'b1;
            end
            if (orphan_hit) begin
                orphan <= 1'b1;
            end
        end
    end

    // Run-control FSM: finish stops new starts, then waits for everything to drain
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (finish) begin
                        state <= ST_DRAIN;
                    end else if (start_en) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (finish) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (ts_empty && (rec_cnt == '0) && !rec_make) begin
                        state <= ST_FINISHED;
                    end
                end
                default: state <= ST_FINISHED;
            endcase
        end
    end

    // Output mapping straight from registered state
    always_comb begin
        rec_valid    = (rec_cnt != '0);
        rec_id       = rid_mem[rec_rd];
        rec_latency  = rlat_mem[rec_rd];
        rec_interval = riv_mem[rec_rd];
        rec_stall    = rst_mem[rec_rd];
        in_flight    = ts_cnt;
        drop_cnt     = drops;
        orphan_err   = orphan;
        finished     = (state == ST_FINISHED);
    end

endmodule
